// File: rtl/hamming_pkg.sv
// Shared helpers for the SECDED Hamming codec family.
//   calc_par_w      : Hamming parity-bit count P for a data width (2^P >= DATA_W+P+1)
//   is_pow2         : true for parity positions 1,2,4,...
//   pos_to_data_idx : data index carried at a non-power-of-two position (3 -> 0, 5 -> 1, ...)
//   data_pos        : inverse mapping, data index -> codeword position
//   dec_status_t    : per-word decode classification, sized for PAR_W <= MAX_PAR_W
//   classify        : syndrome/overall-parity -> classification
package hamming_pkg;

  // Status fields are sized for the widest supported syndrome (DATA_W up to 247).
  localparam int unsigned MAX_PAR_W = 8;

  typedef struct packed {
    logic [MAX_PAR_W-1:0] syndrome;
    logic                 corr;
    logic                 uncorr;
    logic [MAX_PAR_W-1:0] pos;
  } dec_status_t;

  function automatic int unsigned calc_par_w(int unsigned data_w);
    int unsigned p;
    p = 31;
    for (int unsigned k = 30; k >= 1; k--) begin
      if ((64'd1 << k) >= 64'(data_w + k + 1)) p = k;
    end
    return p;
  endfunction

  function automatic bit is_pow2(int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Data bits fill non-parity positions in order, so subtract the parity
  // positions at or below pos and the unused position 0.
  function automatic int unsigned pos_to_data_idx(int unsigned pos);
    int unsigned n_par;
    n_par = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'd1 << k) <= 64'(pos)) n_par++;
    end
    return pos - n_par - 1;
  endfunction

  function automatic int unsigned data_pos(int unsigned idx);
    int unsigned pos;
    pos = 0;
    for (int unsigned p = 3; p < 1024; p++) begin
      if (!is_pow2(p) && pos == 0 && pos_to_data_idx(p) == idx) pos = p;
    end
    return pos;
  endfunction

  // Syndrome 0 with parity error means the overall parity bit itself flipped.
  function automatic dec_status_t classify(logic [MAX_PAR_W-1:0] syn, logic par,
                                           int unsigned code_w);
    dec_status_t st;
    st          = '0;
    st.syndrome = syn;
    if (par) begin
      if (32'(syn) <= code_w - 1) begin
        st.corr = 1'b1;
        st.pos  = syn;
      end else begin
        st.uncorr = 1'b1;
      end
    end else if (syn != '0) begin
      st.uncorr = 1'b1;
    end
    return st;
  endfunction

endpackage

// File: rtl/hamming_secded_decoder_if.sv
// Stream interface of the SECDED decoder: codeword input stream and
// decoded result stream, both valid/ready.
//   master : source of codewords and sink of results (environment side)
//   slave  : the decoder
interface hamming_secded_decoder_if
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned PAR_W  = calc_par_w(DATA_W);
  localparam int unsigned CODE_W = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] code_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PAR_W-1:0]  out_syndrome;
  logic              out_corr;
  logic              out_uncorr;
  logic [PAR_W-1:0]  out_pos;

  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, out_data, out_syndrome, out_corr, out_uncorr, out_pos
  );

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, out_data, out_syndrome, out_corr, out_uncorr, out_pos
  );

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall parity of a SECDED codeword.
//   code_i       : codeword, bit 0 = overall parity, bit i = Hamming position i
//   syndrome_c_o : XOR of the indices of all set positions i >= 1
//   parity_c_o   : XOR of all codeword bits (1 = odd number of errors)
module hamming_syndrome #(
  parameter int unsigned CODE_W = 39,
  parameter int unsigned PAR_W  = 6
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [PAR_W-1:0]  syndrome_c_o,
  output logic              parity_c_o
);

  always_comb begin
    syndrome_c_o = '0;
    for (int unsigned i = 1; i < CODE_W; i++) begin
      if (code_i[i]) syndrome_c_o = syndrome_c_o ^ PAR_W'(i);
    end
    parity_c_o = ^code_i;
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready backpressure.
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : codeword in (in_valid/in_ready/code_in), result out
//                        (out_valid/out_ready/out_data/out_syndrome/out_corr/out_uncorr/out_pos)
//   cnt_clr            : synchronous clear of the error counters
//   corr_cnt/uncorr_cnt: saturating counts of accepted corrected/uncorrectable words
// Build option: define SECDED_ERR_CNT_EN to include the error counters;
// otherwise they read 0 and cnt_clr is ignored.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming_secded_decoder_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     uncorr_cnt
);

  localparam int unsigned PAR_W  = calc_par_w(DATA_W);
  localparam int unsigned CODE_W = DATA_W + PAR_W + 1;

  // Pipeline handshake: each stage loads when empty or when its successor loads.
  logic s1_valid_q;
  logic out_valid_q;
  logic s2_load_c;
  logic s1_load_c;

  assign s2_load_c    = !out_valid_q || bus.out_ready;
  assign s1_load_c    = !s1_valid_q || s2_load_c;
  assign bus.in_ready = s1_load_c;

  // Stage 1: syndrome, parity and raw data extraction
  logic [PAR_W-1:0]  syn_c;
  logic              par_c;
  logic [DATA_W-1:0] raw_data_c;

  hamming_syndrome #(
    .CODE_W (CODE_W),
    .PAR_W  (PAR_W)
  ) u_syndrome (
    .code_i       (bus.code_in),
    .syndrome_c_o (syn_c),
    .parity_c_o   (par_c)
  );

  for (genvar gp = 3; gp < CODE_W; gp++) begin : g_extract
    if (!is_pow2(gp)) begin : g_data
      assign raw_data_c[pos_to_data_idx(gp)] = bus.code_in[gp];
    end
  end

  logic [DATA_W-1:0] s1_data_q;
  logic [PAR_W-1:0]  s1_syn_q;
  logic              s1_par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (s1_load_c) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data_q <= raw_data_c;
        s1_syn_q  <= syn_c;
        s1_par_q  <= par_c;
      end
    end
  end

  // Stage 2: classify and correct. Only data positions matter for the flip;
  // a corrected parity position leaves the data untouched.
  dec_status_t       status_c;
  logic [DATA_W-1:0] flip_c;
  logic [DATA_W-1:0] out_data_d;

  assign status_c = classify(MAX_PAR_W'(s1_syn_q), s1_par_q, CODE_W);

  for (genvar gj = 0; gj < DATA_W; gj++) begin : g_flip
    localparam int unsigned POS = data_pos(gj);
    assign flip_c[gj] = status_c.corr && (s1_syn_q == PAR_W'(POS));
  end

  assign out_data_d = s1_data_q ^ flip_c;

  logic [DATA_W-1:0] out_data_q;
  logic [PAR_W-1:0]  out_syndrome_q;
  logic              out_corr_q;
  logic              out_uncorr_q;
  logic [PAR_W-1:0]  out_pos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_syndrome_q <= '0;
      out_corr_q     <= 1'b0;
      out_uncorr_q   <= 1'b0;
      out_pos_q      <= '0;
    end else if (s2_load_c) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q     <= out_data_d;
        out_syndrome_q <= PAR_W'(status_c.syndrome);
        out_corr_q     <= status_c.corr;
        out_uncorr_q   <= status_c.uncorr;
        out_pos_q      <= PAR_W'(status_c.pos);
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_syndrome = out_syndrome_q;
  assign bus.out_corr     = out_corr_q;
  assign bus.out_uncorr   = out_uncorr_q;
  assign bus.out_pos      = out_pos_q;

`ifdef SECDED_ERR_CNT_EN
  // Saturating statistics, bumped when a flagged result is accepted; clear wins.
  logic             out_fire_c;
  logic [CNT_W-1:0] corr_cnt_q;
  logic [CNT_W-1:0] uncorr_cnt_q;

  assign out_fire_c = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (cnt_clr) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (out_fire_c) begin
      if (out_corr_q && !(&corr_cnt_q))     corr_cnt_q   <= corr_cnt_q + CNT_W'(1);
      if (out_uncorr_q && !(&uncorr_cnt_q)) uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule
